// File: rtl/replay_pkg.sv
// Shared types and constants for the replay command player.
package replay_pkg;

    localparam int unsigned EXITCODE_W = 32;
    localparam int unsigned STEP_CNT_W = 32;
    localparam int unsigned MM_CNT_W   = 32;

    typedef enum logic [1:0] {
        OP_POKE   = 2'd0,
        OP_STEP   = 2'd1,
        OP_EXPECT = 2'd2,
        OP_FINISH = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [MM_CNT_W-1:0] sat_inc(input logic [MM_CNT_W-1:0] v);
        return (v == '1) ? v : v + MM_CNT_W'(1);
    endfunction

endpackage

// File: rtl/replay_step_counter.sv
// Step countdown: loaded with the step count, decremented once per
// enabled cycle; done_c flags the final step cycle.
module replay_step_counter
    import replay_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [STEP_CNT_W-1:0] value,
    input  logic                  enable,
    output logic                  done_c
);

    logic [STEP_CNT_W-1:0] count;

    // Remaining steps; reset discards any pending count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (enable && (count != '0)) begin
            count <= count - STEP_CNT_W'(1);
        end
    end

    assign done_c = (count == STEP_CNT_W'(1));

endmodule

// File: rtl/replay_cmd_player.sv
// Replay command player: consumes a POKE/STEP/EXPECT/FINISH command
// stream and drives a DUT's inputs, clock enable and result reporting.
// Optional build macro REPLAY_FIRST_MISMATCH_EN adds capture of the
// first EXPECT mismatch (port id and observed data).
module replay_cmd_player
    import replay_pkg::*;
#(
    parameter  int unsigned DATA_W    = 64,
    parameter  int unsigned NUM_PORTS = 16,
    localparam int unsigned ID_W      = $clog2(NUM_PORTS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ID_W-1:0]       cmd_id,
    input  logic [DATA_W-1:0]     cmd_data,
    output logic                  poke_valid,
    output logic [ID_W-1:0]       poke_id,
    output logic [DATA_W-1:0]     poke_data,
    output logic [ID_W-1:0]       peek_id,
    input  logic [DATA_W-1:0]     peek_data,
    output logic                  step_en,
    output logic                  exit,
    output logic [EXITCODE_W-1:0] exitcode,
    output logic [MM_CNT_W-1:0]   mismatch_count
`ifdef REPLAY_FIRST_MISMATCH_EN
    ,
    output logic                  first_mm_valid,
    output logic [ID_W-1:0]       first_mm_id,
    output logic [DATA_W-1:0]     first_mm_data
`endif
);

    state_e                state;
    state_e                next_state;
    cmd_op_e               op;
    logic                  accept;
    logic                  load_step;
    logic                  mm_now;
    logic                  step_done_c;
    logic [STEP_CNT_W-1:0] step_n;

    assign op      = cmd_op_e'(cmd_op);
    assign step_n  = STEP_CNT_W'(cmd_data);
    assign peek_id = cmd_id;
    assign mm_now  = accept && (op == OP_EXPECT) && (peek_data != cmd_data);

    replay_step_counter u_step_counter (
        .clock  (clock),
        .reset  (reset),
        .load   (load_step),
        .value  (step_n),
        .enable (state == ST_STEP),
        .done_c (step_done_c)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and command-acceptance decode.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        load_step  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if ((op == OP_STEP) && (step_n != '0)) begin
                        next_state = ST_STEP;
                        load_step  = 1'b1;
                    end else if (op == OP_FINISH) begin
                        next_state = ST_DONE;
                    end
                end
            end
            ST_STEP: begin
                if (step_done_c) begin
                    next_state = ST_IDLE;
                end
            end
            ST_DONE: begin
                next_state = ST_DONE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Handshake and clock-enable outputs track the upcoming state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_ready <= 1'b1;
            step_en   <= 1'b0;
        end else begin
            cmd_ready <= (next_state == ST_IDLE);
            step_en   <= (next_state == ST_STEP);
        end
    end

    // POKE: one-cycle write strobe, id/data hold afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            poke_valid <= 1'b0;
            poke_id    <= '0;
            poke_data  <= '0;
        end else begin
            poke_valid <= accept && (op == OP_POKE);
            if (accept && (op == OP_POKE)) begin
                poke_id   <= cmd_id;
                poke_data <= cmd_data;
            end
        end
    end

    // EXPECT mismatch counting and FINISH result capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mismatch_count <= '0;
            exit           <= 1'b0;
            exitcode       <= '0;
        end else begin
            if (mm_now) begin
                mismatch_count <= sat_inc(mismatch_count);
            end
            if (accept && (op == OP_FINISH)) begin
                exit     <= 1'b1;
                exitcode <= (mismatch_count == '0) ? EXITCODE_W'(cmd_data)
                                                   : EXITCODE_W'(1);
            end
        end
    end

`ifdef REPLAY_FIRST_MISMATCH_EN
    // Capture port id and observed data of the first mismatch only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            first_mm_valid <= 1'b0;
            first_mm_id    <= '0;
            first_mm_data  <= '0;
        end else if (mm_now && !first_mm_valid) begin
            first_mm_valid <= 1'b1;
            first_mm_id    <= cmd_id;
            first_mm_data  <= peek_data;
        end
    end
`endif

endmodule

// File: tb/tb_replay_cmd_player.sv
// Self-checking bench for replay_cmd_player with a behavioural model.
module tb_replay_cmd_player;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned NUM_PORTS = 16;
    localparam int unsigned ID_W      = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ID_W-1:0]   cmd_id;
    logic [DATA_W-1:0] cmd_data;
    logic              poke_valid;
    logic [ID_W-1:0]   poke_id;
    logic [DATA_W-1:0] poke_data;
    logic [ID_W-1:0]   peek_id;
    logic [DATA_W-1:0] peek_data;
    logic              step_en;
    logic              exit;
    logic [31:0]       exitcode;
    logic [31:0]       mismatch_count;
`ifdef REPLAY_FIRST_MISMATCH_EN
    logic              first_mm_valid;
    logic [ID_W-1:0]   first_mm_id;
    logic [DATA_W-1:0] first_mm_data;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    longint unsigned   m_mm;
    logic              m_fv;
    logic [ID_W-1:0]   m_fid;
    logic [DATA_W-1:0] m_fdata;
    logic [ID_W-1:0]   m_pid;
    logic [DATA_W-1:0] m_pdata;

    replay_cmd_player #(.DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS)) dut (
        .clock          (clock),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_id         (cmd_id),
        .cmd_data       (cmd_data),
        .poke_valid     (poke_valid),
        .poke_id        (poke_id),
        .poke_data      (poke_data),
        .peek_id        (peek_id),
        .peek_data      (peek_data),
        .step_en        (step_en),
        .exit           (exit),
        .exitcode       (exitcode),
        .mismatch_count (mismatch_count)
`ifdef REPLAY_FIRST_MISMATCH_EN
        ,
        .first_mm_valid (first_mm_valid),
        .first_mm_id    (first_mm_id),
        .first_mm_data  (first_mm_data)
`endif
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_id    = '0;
        cmd_data  = '0;
        peek_data = '0;
    endtask

    task automatic model_reset();
        m_mm = 0; m_fv = 1'b0; m_fid = '0; m_fdata = '0; m_pid = '0; m_pdata = '0;
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [ID_W-1:0] id,
                             input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] peek);
        if (op == 2'd0) begin
            m_pid = id; m_pdata = data;
        end
        if (op == 2'd2 && peek != data) begin
            if (m_mm < 64'hFFFF_FFFF) m_mm = m_mm + 1;
            if (!m_fv) begin
                m_fv = 1'b1; m_fid = id; m_fdata = peek;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        model_reset();
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    // Present one command while idle and advance one clock.
    task automatic send(input logic [1:0] op, input logic [ID_W-1:0] id,
                        input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] peek);
        cmd_valid = 1'b1; cmd_op = op; cmd_id = id; cmd_data = data; peek_data = peek;
        model_cmd(op, id, data, peek);
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        reset = 1'b1;
        #2;
        n_checks++;
        if ({poke_valid, poke_id, poke_data, step_en, exit, exitcode, mismatch_count} !== '0)
            $display("FAIL reset_outputs: got pv=%0h pid=%0h pd=%0h se=%0h ex=%0h ec=%0h mm=%0h want all 0",
                     poke_valid, poke_id, poke_data, step_en, exit, exitcode, mismatch_count);
        else n_pass++;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %0h want 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_poke();
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] d;
        for (int k = 0; k < 4; k++) begin
            id = (k == 0) ? ID_W'(3) : ID_W'($urandom);
            d  = (k == 0) ? DATA_W'(8'hAB) : {$urandom, $urandom};
            cmd_valid = 1'b1; cmd_op = 2'd0; cmd_id = id; cmd_data = d;
            model_cmd(2'd0, id, d, '0);
            #1;
            n_checks++;
            if (peek_id !== id) $display("FAIL poke_peek_id: got %0h want %0h", peek_id, id);
            else n_pass++;
            cyc();
            cmd_valid = 1'b0;
            n_checks++;
            if ({poke_valid, poke_id, poke_data, cmd_ready} !== {1'b1, m_pid, m_pdata, 1'b1})
                $display("FAIL poke_strobe: got v=%0h id=%0h d=%0h rdy=%0h want v=1 id=%0h d=%0h rdy=1",
                         poke_valid, poke_id, poke_data, cmd_ready, m_pid, m_pdata);
            else n_pass++;
            cyc();
            n_checks++;
            if ({poke_valid, poke_id, poke_data} !== {1'b0, m_pid, m_pdata})
                $display("FAIL poke_hold: got v=%0h id=%0h d=%0h want v=0 id=%0h d=%0h",
                         poke_valid, poke_id, poke_data, m_pid, m_pdata);
            else n_pass++;
        end
    endtask

    task automatic test_step();
        logic [DATA_W-1:0] dl [4];
        logic [DATA_W-1:0] d;
        int unsigned       n;
        int                en_cnt, rdy_low, rises, bad;
        logic              prev_en;
        dl[0] = 64'd5;
        dl[1] = 64'd0;
        dl[2] = DATA_W'($urandom_range(1, 12));
        dl[3] = {($urandom | 32'h1), 32'd3};
        for (int k = 0; k < 4; k++) begin
            d = dl[k];
            n = d[31:0];
            send(2'd1, '0, d, '0);
            if (n != 0) begin
                cmd_valid = 1'b1; cmd_op = 2'd0;
                cmd_id = ID_W'($urandom); cmd_data = {$urandom, $urandom};
            end
            en_cnt = 0; rdy_low = 0; rises = 0; bad = 0; prev_en = 1'b0;
            for (int i = 0; i < int'(n) + 4; i++) begin
                if (cmd_ready) cmd_valid = 1'b0;
                if (step_en) en_cnt++;
                if (!cmd_ready) rdy_low++;
                if (step_en && !prev_en) rises++;
                if (poke_valid || exit) bad++;
                prev_en = step_en;
                cyc();
            end
            cmd_valid = 1'b0;
            n_checks++;
            if (en_cnt != int'(n) || rises > 1)
                $display("FAIL step_en_cycles: got %0d cycles in %0d bursts want %0d in one", en_cnt, rises, n);
            else n_pass++;
            n_checks++;
            if (rdy_low != int'(n)) $display("FAIL step_ready_low: got %0d want %0d", rdy_low, n);
            else n_pass++;
            n_checks++;
            if (bad != 0 || cmd_ready !== 1'b1)
                $display("FAIL step_blocked_cmd: got %0d side effects rdy=%0h want 0 and rdy=1", bad, cmd_ready);
            else n_pass++;
        end
    endtask

    task automatic test_expect_finish();
        logic [31:0] want;
        apply_reset();
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_id = ID_W'(2); cmd_data = 64'h10; peek_data = 64'h10;
        model_cmd(2'd2, ID_W'(2), 64'h10, 64'h10);
        #1;
        n_checks++;
        if (peek_id !== ID_W'(2)) $display("FAIL expect_peek_id: got %0h want 2", peek_id);
        else n_pass++;
        cyc();
        n_checks++;
        if (mismatch_count !== 32'(m_mm)) $display("FAIL expect_match: got %0d want %0d", mismatch_count, m_mm);
        else n_pass++;
        send(2'd2, ID_W'(2), 64'h10, 64'h11);
        n_checks++;
        if (mismatch_count !== 32'(m_mm)) $display("FAIL expect_mismatch: got %0d want %0d", mismatch_count, m_mm);
        else n_pass++;
        send(2'd3, '0, 64'd0, '0);
        want = (m_mm == 0) ? 32'd0 : 32'd1;
        n_checks++;
        if ({exit, exitcode, cmd_ready} !== {1'b1, want, 1'b0})
            $display("FAIL finish_after_mm: got ex=%0h ec=%0h rdy=%0h want ex=1 ec=%0h rdy=0",
                     exit, exitcode, cmd_ready, want);
        else n_pass++;
    endtask

    task automatic test_finish_clean();
        int bad;
        apply_reset();
        for (int k = 0; k < 3; k++) send(2'd0, ID_W'($urandom), {$urandom, $urandom}, '0);
        send(2'd3, '0, 64'd7, '0);
        n_checks++;
        if ({exit, exitcode, cmd_ready} !== {1'b1, 32'd7, 1'b0})
            $display("FAIL finish_clean: got ex=%0h ec=%0h rdy=%0h want ex=1 ec=7 rdy=0", exit, exitcode, cmd_ready);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_id = ID_W'($urandom);
            cmd_data = {$urandom, $urandom}; peek_data = ~cmd_data;
            cyc();
            if ({cmd_ready, step_en, poke_valid, exit, exitcode, mismatch_count} !== {4'b0001, 32'd7, 32'd0})
                bad++;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (bad != 0) $display("FAIL done_absorbing: got %0d disturbed cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid_step();
        apply_reset();
        send(2'd0, ID_W'(5), 64'h1234, '0);
        send(2'd2, ID_W'(1), 64'h1, 64'h2);
        send(2'd1, '0, 64'd10, '0);
        cyc();
        cyc();
        n_checks++;
        if (step_en !== 1'b1) $display("FAIL midstep_active: got %0h want 1", step_en);
        else n_pass++;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({step_en, poke_valid, poke_id, poke_data, exit, exitcode, mismatch_count} !== '0)
            $display("FAIL midstep_async_reset: got se=%0h pid=%0h pd=%0h mm=%0h want all 0",
                     step_en, poke_id, poke_data, mismatch_count);
        else n_pass++;
        cyc();
        reset = 1'b0;
        cyc();
        n_checks++;
        if ({cmd_ready, step_en, mismatch_count} !== {1'b1, 1'b0, 32'd0})
            $display("FAIL midstep_release: got rdy=%0h se=%0h mm=%0h want rdy=1 se=0 mm=0",
                     cmd_ready, step_en, mismatch_count);
        else n_pass++;
        cyc();
        n_checks++;
        if (step_en !== 1'b0) $display("FAIL midstep_count_discarded: got %0h want 0", step_en);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [1:0]        op;
        logic [DATA_W-1:0] d;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2;
            d  = {$urandom, $urandom};
            cmd_valid = 1'b1; cmd_op = op; cmd_id = ID_W'($urandom); cmd_data = d;
            peek_data = ($urandom_range(0, 1) == 0) ? d : {$urandom, $urandom};
            n_checks++;
            if (cmd_ready !== 1'b1) $display("FAIL b2b_ready: iter %0d got %0h want 1", i, cmd_ready);
            else n_pass++;
            model_cmd(op, cmd_id, d, peek_data);
            cyc();
            n_checks++;
            if ({poke_valid, poke_id, poke_data} !== {(op == 2'd0), m_pid, m_pdata})
                $display("FAIL b2b_poke: iter %0d got v=%0h id=%0h d=%0h want v=%0h id=%0h d=%0h",
                         i, poke_valid, poke_id, poke_data, (op == 2'd0), m_pid, m_pdata);
            else n_pass++;
            n_checks++;
            if (mismatch_count !== 32'(m_mm))
                $display("FAIL b2b_mismatch_count: iter %0d got %0d want %0d", i, mismatch_count, m_mm);
            else n_pass++;
`ifdef REPLAY_FIRST_MISMATCH_EN
            n_checks++;
            if ({first_mm_valid, first_mm_id, first_mm_data} !== {m_fv, m_fid, m_fdata})
                $display("FAIL b2b_first_mm: iter %0d got v=%0h id=%0h d=%0h want v=%0h id=%0h d=%0h",
                         i, first_mm_valid, first_mm_id, first_mm_data, m_fv, m_fid, m_fdata);
            else n_pass++;
`endif
        end
        cmd_valid = 1'b0;
    endtask

`ifdef REPLAY_FIRST_MISMATCH_EN
    task automatic test_first_mm();
        logic [DATA_W-1:0] p1;
        apply_reset();
        n_checks++;
        if (first_mm_valid !== 1'b0) $display("FAIL first_mm_reset: got %0h want 0", first_mm_valid);
        else n_pass++;
        p1 = {$urandom, $urandom};
        send(2'd2, ID_W'(4), ~p1, p1);
        send(2'd2, ID_W'(6), 64'h5, 64'h6);
        n_checks++;
        if ({first_mm_valid, first_mm_id, first_mm_data} !== {1'b1, ID_W'(4), p1})
            $display("FAIL first_mm_capture: got v=%0h id=%0h d=%0h want v=1 id=4 d=%0h",
                     first_mm_valid, first_mm_id, first_mm_data, p1);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_poke();
        test_step();
        test_expect_finish();
        test_finish_clean();
        test_reset_mid_step();
        test_back_to_back();
`ifdef REPLAY_FIRST_MISMATCH_EN
        test_first_mm();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
